// File: rtl/ariane_emc_flash_rd.sv
// rtl/ariane_emc_flash_rd.sv - asynchronous-mode half-word read engine for parallel NOR flash
module ariane_emc_flash_rd #(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned ACCESS_CYC  = 8,
   parameter int unsigned RECOVER_CYC = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        read_req,
   input  logic [26:0] read_addr,
   output logic        read_ready,
   output logic [15:0] read_data,
   output logic        read_valid,
   input  logic [15:0] flash_dq_i,
   output logic [15:0] flash_dq_o,
   output logic [15:0] flash_dq_t,
   output logic [26:0] flash_a,
   output logic        flash_we_b,
   output logic        flash_oe_b,
   output logic        flash_ce_b,
   output logic        flash_adv_b,
   input  logic        flash_wait
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   // The idle cycle in which the next request is accepted counts as the last
   // recovery cycle, so RECOVER itself lasts RECOVER_CYC-1 cycles and is
   // skipped entirely when RECOVER_CYC is 1.
   localparam logic [7:0] SETUP_LOAD   = 8'(SETUP_CYC - 1);
   localparam logic [7:0] ACCESS_LOAD  = 8'(ACCESS_CYC - 1);
   localparam logic [7:0] RECOVER_LOAD = (RECOVER_CYC > 1) ? 8'(RECOVER_CYC - 2) : 8'd0;
   localparam logic       HAS_RECOVER  = (RECOVER_CYC > 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [26:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        ce_b_q, ce_b_d;
   logic        oe_b_q, oe_b_d;
   logic        adv_b_q, adv_b_d;

   // Asynchronous mode never looks at WAIT, and the half-word address drops bit 0.
   logic unused_inputs;
   assign unused_inputs = ^{flash_wait, read_addr[0]};

   // State, phase counter and every pin-facing register; pins reset to idle at once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= 27'd0;
         data_q  <= 16'd0;
         valid_q <= 1'b0;
         ce_b_q  <= 1'b1;
         oe_b_q  <= 1'b1;
         adv_b_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ce_b_q  <= ce_b_d;
         oe_b_q  <= oe_b_d;
         adv_b_q <= adv_b_d;
      end
   end

   // Next-state and next pin values; read_valid defaults low so it pulses for one cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ce_b_d  = ce_b_q;
      oe_b_d  = oe_b_q;
      adv_b_d = adv_b_q;
      case (state_q)
         IDLE: begin
            if (read_req) begin
               addr_d  = {read_addr[26:1], 1'b0};
               ce_b_d  = 1'b0;
               adv_b_d = 1'b0;
               oe_b_d  = 1'b1;
               cnt_d   = SETUP_LOAD;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == 8'd0) begin
               adv_b_d = 1'b1;
               oe_b_d  = 1'b0;
               cnt_d   = ACCESS_LOAD;
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACCESS: begin
            if (cnt_q == 8'd0) begin
               data_d  = flash_dq_i;
               valid_d = 1'b1;
               oe_b_d  = 1'b1;
               ce_b_d  = 1'b1;
               adv_b_d = 1'b1;
               cnt_d   = RECOVER_LOAD;
               state_d = HAS_RECOVER ? RECOVER : IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RECOVER: begin
            if (cnt_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign read_ready  = (state_q == IDLE);
   assign read_data   = data_q;
   assign read_valid  = valid_q;
   assign flash_a     = addr_q;
   assign flash_ce_b  = ce_b_q;
   assign flash_oe_b  = oe_b_q;
   assign flash_adv_b = adv_b_q;
   assign flash_we_b  = 1'b1;
   assign flash_dq_o  = 16'h0000;
   assign flash_dq_t  = 16'hFFFF;

endmodule

// File: tb/tb_ariane_emc_flash_rd.sv
// tb/tb_ariane_emc_flash_rd.sv - directed bench for ariane_emc_flash_rd
module tb_ariane_emc_flash_rd;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] dq_i = 16'h0000;
   logic        fwait = 1'b0;

   logic        req0 = 1'b0;
   logic [26:0] addr0 = 27'd0;
   logic        ready0, valid0, we0, oe0, ce0, adv0;
   logic [15:0] data0, dqo0, dqt0;
   logic [26:0] a0;

   logic        req1 = 1'b0;
   logic [26:0] addr1 = 27'd0;
   logic        ready1, valid1, we1, oe1, ce1, adv1;
   logic [15:0] data1, dqo1, dqt1;
   logic [26:0] a1;

   int ncmp = 0;
   int nerr = 0;
   int bad_const = 0;
   int vcount;
   logic [4:0] vec;
   logic [4:0] exp_vec;

   always #5 clk = ~clk;

   ariane_emc_flash_rd u_dflt (
      .clk(clk), .rstn(rstn), .read_req(req0), .read_addr(addr0), .read_ready(ready0),
      .read_data(data0), .read_valid(valid0), .flash_dq_i(dq_i), .flash_dq_o(dqo0),
      .flash_dq_t(dqt0), .flash_a(a0), .flash_we_b(we0), .flash_oe_b(oe0),
      .flash_ce_b(ce0), .flash_adv_b(adv0), .flash_wait(fwait)
   );

   ariane_emc_flash_rd #(.SETUP_CYC(1), .ACCESS_CYC(1), .RECOVER_CYC(1)) u_fast (
      .clk(clk), .rstn(rstn), .read_req(req1), .read_addr(addr1), .read_ready(ready1),
      .read_data(data1), .read_valid(valid1), .flash_dq_i(dq_i), .flash_dq_o(dqo1),
      .flash_dq_t(dqt1), .flash_a(a1), .flash_we_b(we1), .flash_oe_b(oe1),
      .flash_ce_b(ce1), .flash_adv_b(adv1), .flash_wait(fwait)
   );

   // Constant pins are watched on every falling edge, through reset as well.
   always @(negedge clk) begin
      if (we0 !== 1'b1 || dqt0 !== 16'hFFFF || dqo0 !== 16'h0000 ||
          we1 !== 1'b1 || dqt1 !== 16'hFFFF || dqo1 !== 16'h0000)
         bad_const++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values, sampled while reset is held.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready0", ready0, 1);
      chk("rst_pins0", {ce0, oe0, adv0}, 3'b111);
      chk("rst_a0", a0, 0);
      chk("rst_data0", data0, 0);
      chk("rst_valid0", valid0, 0);
      chk("rst_ready1", ready1, 1);
      chk("rst_pins1", {ce1, oe1, adv1}, 3'b111);
      rstn = 1'b1;
      step();

      // Single default read: {ce,adv,oe,valid,ready} tracked every cycle after E0.
      dq_i = 16'hBEEF;
      addr0 = 27'h0001235;
      req0 = 1'b1;
      step();
      req0 = 1'b0;
      chk("s1_a", a0, 27'h0001234);
      chk("s1_e0_pins", {ce0, adv0, oe0, valid0, ready0}, 5'b00100);
      for (int k = 1; k <= 12; k++) begin
         fwait = k[0];
         step();
         exp_vec[4] = (k < 10) ? 1'b0 : 1'b1;
         exp_vec[3] = (k < 2) ? 1'b0 : 1'b1;
         exp_vec[2] = (k >= 2 && k < 10) ? 1'b0 : 1'b1;
         exp_vec[1] = (k == 10);
         exp_vec[0] = (k >= 11);
         vec = {ce0, adv0, oe0, valid0, ready0};
         chk($sformatf("s1_k%0d", k), vec, exp_vec);
      end
      chk("s1_data", data0, 16'hBEEF);
      chk("s1_a_hold", a0, 27'h0001234);

      // Held request: second accept 12 cycles after the first.
      dq_i = 16'h1111;
      addr0 = 27'h10;
      req0 = 1'b1;
      step();
      addr0 = 27'h12;
      chk("s2_a_first", a0, 27'h10);
      vcount = 0;
      for (int k = 1; k <= 24; k++) begin
         step();
         if (k == 12) req0 = 1'b0;
         if (valid0) vcount++;
         if (k == 10) chk("s2_valid_first", valid0, 1);
         if (k == 11) chk("s2_a_k11", {ce0, a0}, {1'b1, 27'h10});
         if (k == 12) chk("s2_accept2", {ce0, adv0, ready0, a0}, {3'b000, 27'h12});
         if (k == 22) chk("s2_valid_second", valid0, 1);
         if (k == 24) chk("s2_ready_end", ready0, 1);
      end
      chk("s2_vcount", vcount, 2);

      // Minimal timing on the fast instance, with a back-to-back accept at E0+3.
      dq_i = 16'h1234;
      addr1 = 27'h100;
      req1 = 1'b1;
      step();
      addr1 = 27'h201;
      chk("s3_e0", {ce1, adv1, oe1, valid1, ready1}, 5'b00100);
      step();
      chk("s3_k1", {ce1, adv1, oe1, valid1, ready1}, 5'b01000);
      step();
      chk("s3_k2", {ce1, adv1, oe1, valid1, ready1}, 5'b11111);
      chk("s3_data", data1, 16'h1234);
      dq_i = 16'h4321;
      step();
      req1 = 1'b0;
      chk("s3_k3", {ce1, adv1, oe1, valid1, ready1, a1}, {5'b00100, 27'h200});
      step();
      chk("s3_k4", {ce1, adv1, oe1, valid1}, 4'b0100);
      step();
      chk("s3_k5", {valid1, data1}, {1'b1, 16'h4321});

      // Address and request changes during ACCESS are ignored.
      dq_i = 16'h5A5A;
      addr0 = 27'h0000100;
      req0 = 1'b1;
      step();
      req0 = 1'b0;
      vcount = 0;
      bad_const = bad_const;
      for (int k = 1; k <= 14; k++) begin
         if (k >= 3 && k <= 8) begin
            addr0 = 27'h7FFFFFE;
            req0 = k[0];
         end else begin
            req0 = 1'b0;
         end
         step();
         if (valid0) vcount++;
         if (k == 10) chk("s4_valid_data", {valid0, data0}, {1'b1, 16'h5A5A});
         if (k == 9) chk("s4_a_mid", a0, 27'h0000100);
         if (k == 14) chk("s4_no_extra", {ce0, ready0, a0}, {2'b11, 27'h0000100});
      end
      req0 = 1'b0;
      chk("s4_vcount", vcount, 1);

      // Reset in the middle of ACCESS.
      dq_i = 16'h7777;
      addr0 = 27'h0000400;
      req0 = 1'b1;
      step();
      req0 = 1'b0;
      repeat (4) step();
      chk("s5_in_access", {ce0, oe0, adv0}, 3'b001);
      #1 rstn = 1'b0;
      #1;
      chk("s5_async_pins", {ce0, oe0, adv0, valid0, ready0}, 5'b11101);
      #1 rstn = 1'b1;
      vcount = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (valid0) vcount++;
      end
      chk("s5_lost_valid", vcount, 0);
      chk("s5_after_rst", {ready0, data0, a0}, {1'b1, 16'h0000, 27'h0});
      dq_i = 16'hC0DE;
      addr0 = 27'h0ABCDEF;
      req0 = 1'b1;
      step();
      req0 = 1'b0;
      repeat (10) step();
      chk("s5_new_read", {valid0, data0, a0}, {1'b1, 16'hC0DE, 27'h0ABCDEE});
      repeat (2) step();
      chk("s5_ready", ready0, 1);

      chk("const_pins", bad_const, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
